// File: rtl/ksm_pkg.sv
// Shared constants for the KSM terminal video-RAM path: window base, bus widths
// and the CPU-side arbiter state encoding.
package ksm_pkg;

   localparam int KSM_AW = 12;
   localparam int KSM_DW = 16;
   localparam logic [15:0] VRAM_BASE = 16'o140000;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE   = 3'd0;
   localparam state_t S_ISSUE  = 3'd1;
   localparam state_t S_RDWAIT = 3'd2;
   localparam state_t S_ACK    = 3'd3;
   localparam state_t S_GAP    = 3'd4;

endpackage

// File: rtl/ksm_vram_arb.sv
// Single-port VRAM arbiter: video fetch owns any slot it asks for (2-cycle fixed latency),
// the Wishbone CPU fills the remaining slots and is acked after 2 (write) or 3 (read) cycles.
module ksm_vram_arb
   import ksm_pkg::*;
#(
   parameter int AW = KSM_AW,
   parameter int DW = KSM_DW
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   input  logic [15:0]   wb_adr_i,
   input  logic [DW-1:0] wb_dat_i,
   output logic [DW-1:0] wb_dat_o,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   input  logic          wb_we_i,
   input  logic [1:0]    wb_sel_i,
   output logic          wb_ack_o,
   input  logic          vid_req_i,
   input  logic [AW-1:0] vid_adr_i,
   output logic [DW-1:0] vid_dat_o,
   output logic          vid_vld_o,
   output logic [AW-1:0] ram_adr_o,
   output logic [DW-1:0] ram_dat_o,
   output logic          ram_we_o,
   output logic [1:0]    ram_be_o,
   input  logic [DW-1:0] ram_dat_i,
   output logic [15:0]   stall_cnt_o
);

   state_t state;
   logic   cpu_we;
   logic   vid_p1;
   logic   cpu_req;
   logic   unused_adr;

   assign cpu_req    = wb_cyc_i & wb_stb_i;
   assign unused_adr = ^{wb_adr_i[15:AW+1], wb_adr_i[0]};

   // The RAM word arrives in the same cycle as the vld bit, so it is forwarded
   // directly to keep video latency at two cycles; zero when no fetch is valid.
   assign vid_dat_o = vid_vld_o ? ram_dat_i : '0;

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i) begin
         state       <= S_IDLE;
         cpu_we      <= 1'b0;
         vid_p1      <= 1'b0;
         vid_vld_o   <= 1'b0;
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
         ram_adr_o   <= '0;
         ram_dat_o   <= '0;
         ram_we_o    <= 1'b0;
         ram_be_o    <= 2'b00;
         stall_cnt_o <= '0;
      end else begin
         vid_p1    <= vid_req_i;
         vid_vld_o <= vid_p1;
         wb_ack_o  <= 1'b0;

         // Slot ownership: video first, then a CPU access being accepted this cycle.
         if (vid_req_i) begin
            ram_adr_o <= vid_adr_i;
            ram_we_o  <= 1'b0;
            ram_be_o  <= 2'b11;
         end else if (state == S_IDLE && cpu_req) begin
            ram_adr_o <= wb_adr_i[AW:1];
            ram_dat_o <= wb_dat_i;
            ram_we_o  <= wb_we_i;
            ram_be_o  <= wb_we_i ? wb_sel_i : 2'b11;
         end else begin
            ram_we_o  <= 1'b0;
            ram_be_o  <= 2'b00;
         end

         case (state)
            S_IDLE: begin
               if (cpu_req) begin
                  if (vid_req_i) begin
                     if (stall_cnt_o != 16'hFFFF)
                        stall_cnt_o <= stall_cnt_o + 16'd1;
                  end else begin
                     cpu_we <= wb_we_i;
                     state  <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (cpu_we) begin
                  wb_ack_o <= 1'b1;
                  state    <= S_ACK;
               end else begin
                  state    <= S_RDWAIT;
               end
            end
            S_RDWAIT: begin
               wb_dat_o <= ram_dat_i;
               wb_ack_o <= 1'b1;
               state    <= S_ACK;
            end
            S_ACK:   state <= S_GAP;
            // Master still has stb high here; ignoring it avoids a duplicate access.
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ksm_vram_arb.sv
// Randomized bench for ksm_vram_arb: a cycle-indexed transaction model predicts acks,
// RAM slot usage, video returns and the stall count from the timing rules.
module tb_ksm_vram_arb;
   import ksm_pkg::*;

   localparam int NC = 4096;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i;
   logic [15:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic [15:0] wb_dat_o;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [1:0]  wb_sel_i;
   logic        wb_ack_o;
   logic        vid_req_i;
   logic [11:0] vid_adr_i;
   logic [15:0] vid_dat_o;
   logic        vid_vld_o;
   logic [11:0] ram_adr_o;
   logic [15:0] ram_dat_o;
   logic        ram_we_o;
   logic [1:0]  ram_be_o;
   logic [15:0] ram_dat_i;
   logic [15:0] stall_cnt_o;

   ksm_vram_arb dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
      .wb_sel_i(wb_sel_i), .wb_ack_o(wb_ack_o), .vid_req_i(vid_req_i), .vid_adr_i(vid_adr_i),
      .vid_dat_o(vid_dat_o), .vid_vld_o(vid_vld_o), .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o),
      .ram_we_o(ram_we_o), .ram_be_o(ram_be_o), .ram_dat_i(ram_dat_i), .stall_cnt_o(stall_cnt_o)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   // Synchronous RAM with one cycle of read latency and byte-lane writes.
   logic [15:0] bram [4096];
   always @(posedge wb_clk_i) begin
      ram_dat_i <= bram[ram_adr_o];
      if (ram_we_o) begin
         if (ram_be_o[0]) bram[ram_adr_o][7:0]  <= ram_dat_o[7:0];
         if (ram_be_o[1]) bram[ram_adr_o][15:8] <= ram_dat_o[15:8];
      end
   end

   // Expected behaviour per cycle index.
   logic        exp_ack   [NC];
   logic        exp_rchk  [NC];
   logic [15:0] exp_rdat  [NC];
   logic        exp_we    [NC];
   logic [11:0] exp_wadr  [NC];
   logic [1:0]  exp_wbe   [NC];
   logic [15:0] exp_wdat  [NC];
   logic        exp_vslot [NC];
   logic [11:0] exp_vadr  [NC];
   logic        exp_vld   [NC];
   logic [15:0] exp_vdat  [NC];
   logic [15:0] ref_mem   [4096];
   logic [15:0] stall_ref;
   logic        rst_prev;
   int          free_at;
   int          c;
   int          n_vec;
   int          n_err;
   int          vld_seen;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, c, got, exp);
      end
   endtask

   task automatic clear_exp(input int i);
      exp_ack[i] = 1'b0;  exp_rchk[i] = 1'b0; exp_we[i] = 1'b0;
      exp_vslot[i] = 1'b0; exp_vld[i] = 1'b0;
   endtask

   // One clock: check this cycle's outputs, drive this cycle's inputs, predict consequences.
   task automatic step(input logic rst, input logic vreq, input logic [11:0] vadr,
                       input logic cs, input logic we, input logic [15:0] adr,
                       input logic [1:0] sel, input logic [15:0] dat);
      logic [11:0] w;
      if (c > 0) begin
         chk("ack", wb_ack_o, exp_ack[c]);
         if (exp_rchk[c]) chk("rd_data", wb_dat_o, exp_rdat[c]);
         chk("ram_we", ram_we_o, exp_we[c]);
         if (exp_we[c]) begin
            chk("wr_adr", ram_adr_o, exp_wadr[c]);
            chk("wr_be", ram_be_o, exp_wbe[c]);
            chk("wr_dat", ram_dat_o, exp_wdat[c]);
         end
         if (exp_vslot[c]) chk("vid_slot_adr", ram_adr_o, exp_vadr[c]);
         chk("vid_vld", vid_vld_o, exp_vld[c]);
         if (exp_vld[c]) chk("vid_dat", vid_dat_o, exp_vdat[c]);
         chk("stall_cnt", stall_cnt_o, stall_ref);
         if (rst_prev) begin
            chk("rst_be", ram_be_o, 2'b00);
            chk("rst_adr", ram_adr_o, 12'd0);
            chk("rst_ramdat", ram_dat_o, 16'd0);
            chk("rst_wbdat", wb_dat_o, 16'd0);
            chk("rst_viddat", vid_dat_o, 16'd0);
         end
         if (vid_vld_o === 1'b1) vld_seen++;
      end

      wb_rst_i  = ~rst;
      vid_req_i = vreq;
      vid_adr_i = vadr;
      wb_cyc_i  = cs;
      wb_stb_i  = cs;
      wb_we_i   = we;
      wb_adr_i  = adr;
      wb_sel_i  = sel;
      wb_dat_i  = dat;

      rst_prev = rst;
      if (rst) begin
         for (int i = c + 1; i <= c + 3; i++) clear_exp(i);
         free_at   = c + 1;
         stall_ref = 16'd0;
      end else begin
         if (vreq) begin
            exp_vslot[c+1] = 1'b1;
            exp_vadr[c+1]  = vadr;
            exp_vld[c+2]   = 1'b1;
            exp_vdat[c+2]  = ref_mem[vadr];
         end
         if (cs && c >= free_at) begin
            if (vreq) begin
               if (stall_ref != 16'hFFFF) stall_ref = stall_ref + 16'd1;
            end else begin
               w = adr[12:1];
               if (we) begin
                  if (sel[0]) ref_mem[w][7:0]  = dat[7:0];
                  if (sel[1]) ref_mem[w][15:8] = dat[15:8];
                  exp_we[c+1]   = 1'b1;
                  exp_wadr[c+1] = w;
                  exp_wbe[c+1]  = sel;
                  exp_wdat[c+1] = dat;
                  exp_ack[c+2]  = 1'b1;
                  free_at       = c + 4;
               end else begin
                  exp_ack[c+3]  = 1'b1;
                  exp_rchk[c+3] = 1'b1;
                  exp_rdat[c+3] = ref_mem[w];
                  free_at       = c + 5;
               end
            end
         end
      end
      @(negedge wb_clk_i);
      c++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 16'd0, 2'b00, 16'd0);
   endtask

   task automatic reset_for(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 16'd0, 2'b00, 16'd0);
   endtask

   // Holds stb until the predicted ack, through the ack cycle, plus 'hold' extra cycles.
   task automatic cpu_op(input logic we, input logic [15:0] adr, input logic [1:0] sel,
                         input logic [15:0] dat, input int hold, output logic [15:0] rd);
      logic done;
      done = 1'b0;
      rd   = 16'd0;
      for (int n = 0; n < 40 && !done; n++) begin
         step(1'b0, 1'b0, 12'd0, 1'b1, we, adr, sel, dat);
         if (exp_ack[c]) begin
            done = 1'b1;
            rd   = wb_dat_o;
         end
      end
      for (int h = 0; h <= hold; h++) step(1'b0, 1'b0, 12'd0, 1'b1, we, adr, sel, dat);
      chk("op_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      logic [15:0] rd;
      logic        m_act, m_tail, m_we;
      logic [15:0] m_adr, m_dat;
      logic [1:0]  m_sel;
      int          pv, pc;
      logic        drv, vr;

      c = 0; n_vec = 0; n_err = 0; vld_seen = 0;
      free_at = 0; stall_ref = 16'd0; rst_prev = 1'b0;
      for (int i = 0; i < NC; i++) clear_exp(i);
      wb_rst_i = 1'b0; vid_req_i = 1'b0; vid_adr_i = 12'd0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      wb_we_i = 1'b0; wb_adr_i = 16'd0; wb_sel_i = 2'b00; wb_dat_i = 16'd0;
      @(negedge wb_clk_i);

      reset_for(3);
      for (int i = 0; i < 16; i++)
         cpu_op(1'b1, VRAM_BASE + 16'(i * 2), 2'b11, 16'($urandom), 0, rd);
      idle(2);

      // Word write at 140010 with stb held through the gap cycle, then readback.
      cpu_op(1'b1, 16'o140010, 2'b11, 16'o052525, 1, rd);
      idle(2);
      cpu_op(1'b0, 16'o140010, 2'b11, 16'd0, 0, rd);
      chk("readback_052525", rd, 16'o052525);
      idle(2);

      // Upper-byte write merges with the existing lower byte.
      cpu_op(1'b1, 16'o140020, 2'b11, 16'h1234, 0, rd);
      idle(1);
      cpu_op(1'b1, 16'o140020, 2'b10, 16'hAB00, 0, rd);
      idle(1);
      cpu_op(1'b0, 16'o140020, 2'b11, 16'd0, 0, rd);
      chk("byte_merge", rd, 16'hAB34);
      idle(2);

      // Video and CPU in the same idle cycle: CPU is deferred by one.
      step(1'b0, 1'b1, 12'd4, 1'b1, 1'b0, 16'o140010, 2'b11, 16'd0);
      cpu_op(1'b0, 16'o140010, 2'b11, 16'd0, 0, rd);
      chk("stall_one", stall_cnt_o, 16'd1);
      idle(2);

      // 100 back-to-back video requests starve a pending CPU write.
      reset_for(2);
      vld_seen = 0;
      for (int i = 0; i < 100; i++)
         step(1'b0, 1'b1, 12'($urandom_range(0, 15)), 1'b1, 1'b1, 16'o140030, 2'b11, 16'h5A5A);
      cpu_op(1'b1, 16'o140030, 2'b11, 16'h5A5A, 0, rd);
      chk("stall_100", stall_cnt_o, 16'd100);
      chk("vld_count_100", vld_seen, 100);
      idle(2);

      // Random mix with varying video density.
      m_act = 1'b0; m_tail = 1'b0; m_we = 1'b0; m_adr = VRAM_BASE; m_dat = 16'd0; m_sel = 2'b11;
      for (int ph = 0; ph < 5; ph++) begin
         case (ph)
            0: pv = 0;
            1: pv = 15;
            2: pv = 50;
            3: pv = 90;
            default: pv = 30;
         endcase
         pc = (ph == 3) ? 80 : 35;
         for (int i = 0; i < 480; i++) begin
            if (!m_act && !m_tail && $urandom_range(0, 99) < pc) begin
               m_act = 1'b1;
               m_we  = 1'($urandom_range(0, 1));
               m_adr = VRAM_BASE + 16'($urandom_range(0, 15) * 2) + 16'($urandom_range(0, 1));
               m_sel = 2'($urandom_range(0, 3));
               m_dat = 16'($urandom);
            end
            if (m_act && $urandom_range(0, 59) == 0) m_act = 1'b0;
            drv = m_act | m_tail;
            vr  = ($urandom_range(0, 99) < pv);
            step(1'b0, vr, 12'($urandom_range(0, 15)), drv, m_we, m_adr, m_sel, m_dat);
            m_tail = 1'b0;
            if (m_act && exp_ack[c-1]) begin
               m_act  = 1'b0;
               m_tail = 1'($urandom_range(0, 1));
            end
         end
      end
      idle(6);

      // Reset while a read sits in RDWAIT: ack must never appear.
      step(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 16'o140010, 2'b11, 16'd0);
      step(1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 16'o140010, 2'b11, 16'd0);
      step(1'b1, 1'b0, 12'd0, 1'b1, 1'b0, 16'o140010, 2'b11, 16'd0);
      idle(4);
      cpu_op(1'b1, 16'o140040, 2'b11, 16'hC0DE, 0, rd);
      idle(1);
      cpu_op(1'b0, 16'o140040, 2'b11, 16'd0, 0, rd);
      chk("resume_after_rst", rd, 16'hC0DE);
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
